// File: rtl/seven_seg_scan_driver_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan driver.
package seven_seg_scan_driver_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    BLANK = 2'd2,
    SHOW  = 2'd3
  } scan_state_e;

  localparam int         NUM_DIGITS = 8;
  localparam logic [7:0] BLANK_SEG  = 8'hFF;

  // Active-low one-hot anode pattern for the given digit.
  function automatic logic [7:0] anode_drive_n(input logic [2:0] idx);
    return ~(8'b0000_0001 << idx);
  endfunction

endpackage

// File: rtl/seven_seg_scan_driver_scan_tick_counter.sv
// Per-digit slot prescaler: counts 0..SCAN_DIV-1, flags the last cycle of a
// slot and whether the following cycle falls in the blanking window.
module scan_tick_counter #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc,
  output logic o_blank
);

  localparam int            CW        = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] TC_VAL    = CW'(SCAN_DIV - 1);
  localparam logic [CW:0]   BLANK_LIM = (CW + 1)'((BLANK_CYCLES == 0) ? 1 : BLANK_CYCLES);
  localparam bit            HAS_BLANK = (BLANK_CYCLES != 0);

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic          w_at_tc;

  assign w_at_tc = (r_count == TC_VAL);

  // Next count; the blank flag looks at it so the FSM can register its outputs.
  always_comb begin
    w_count_next = r_count;
    if (i_clear) begin
      w_count_next = {CW{1'b0}};
    end else if (i_enable) begin
      if (w_at_tc) begin
        w_count_next = {CW{1'b0}};
      end else begin
        w_count_next = r_count + CW'(1);
      end
    end else begin
      w_count_next = r_count;
    end
  end

  // Slot counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= {CW{1'b0}};
    end else begin
      r_count <= w_count_next;
    end
  end

  assign o_tc    = i_enable & w_at_tc;
  assign o_blank = HAS_BLANK & ({1'b0, w_count_next} < BLANK_LIM);

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Eight-digit multiplexed display driver: snapshots the segment bytes once per
// frame and scans them out one digit per slot with a dark guard band.
module seven_seg_scan_driver
  import seven_seg_scan_driver_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       Enable,
  input  logic [7:0] Seven_Seg0,
  input  logic [7:0] Seven_Seg1,
  input  logic [7:0] Seven_Seg2,
  input  logic [7:0] Seven_Seg3,
  input  logic [7:0] Seven_Seg4,
  input  logic [7:0] Seven_Seg5,
  input  logic [7:0] Seven_Seg6,
  input  logic [7:0] Seven_Seg7,
  output logic [7:0] Digit_Select,
  output logic [7:0] Segment_Out,
  output logic [2:0] Digit_Index,
  output logic       Frame_Start
);

  scan_state_e                r_state;
  scan_state_e                w_state_next;
  logic [2:0]                 r_digit_index;
  logic [2:0]                 w_index_next;
  logic [NUM_DIGITS-1:0][7:0] r_shadow;
  logic [NUM_DIGITS-1:0][7:0] w_shadow_next;
  logic [NUM_DIGITS-1:0][7:0] w_seg_in;
  logic [7:0]                 r_digit_select;
  logic [7:0]                 w_select_next;
  logic [7:0]                 r_segment_out;
  logic [7:0]                 w_segment_next;
  logic                       r_frame_start;
  logic                       w_frame_start_next;
  logic                       w_slot_run;
  logic                       w_tc;
  logic                       w_blank;

  assign w_seg_in   = {Seven_Seg7, Seven_Seg6, Seven_Seg5, Seven_Seg4,
                       Seven_Seg3, Seven_Seg2, Seven_Seg1, Seven_Seg0};
  assign w_slot_run = Enable && ((r_state == BLANK) || (r_state == SHOW));

  scan_tick_counter #(
    .SCAN_DIV    (SCAN_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_scan_tick_counter (
    .i_clk   (Clock),
    .i_rst_n (Reset_n),
    .i_clear (!w_slot_run),
    .i_enable(w_slot_run),
    .o_tc    (w_tc),
    .o_blank (w_blank)
  );

  // Next state and next value of every registered output.
  always_comb begin
    w_state_next  = r_state;
    w_index_next  = r_digit_index;
    w_shadow_next = r_shadow;
    if (!Enable) begin
      w_state_next = IDLE;
      w_index_next = 3'd0;
    end else begin
      case (r_state)
        IDLE: w_state_next = LOAD;
        LOAD: begin
          w_shadow_next = w_seg_in;
          w_index_next  = 3'd0;
          w_state_next  = w_blank ? BLANK : SHOW;
        end
        BLANK, SHOW: begin
          if (w_tc && (r_digit_index == 3'd7)) begin
            w_state_next = LOAD;
            w_index_next = 3'd0;
          end else begin
            if (w_tc) begin
              w_index_next = r_digit_index + 3'd1;
            end else begin
              w_index_next = r_digit_index;
            end
            w_state_next = w_blank ? BLANK : SHOW;
          end
        end
        default: begin
          w_state_next = IDLE;
          w_index_next = 3'd0;
        end
      endcase
    end
    w_frame_start_next = (w_state_next == LOAD);
    if (w_state_next == SHOW) begin
      w_select_next  = anode_drive_n(w_index_next);
      w_segment_next = w_shadow_next[w_index_next];
    end else begin
      w_select_next  = 8'hFF;
      w_segment_next = BLANK_SEG;
    end
  end

  // State, snapshot and output registers.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state        <= IDLE;
      r_digit_index  <= 3'd0;
      r_shadow       <= {NUM_DIGITS{BLANK_SEG}};
      r_digit_select <= 8'hFF;
      r_segment_out  <= BLANK_SEG;
      r_frame_start  <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_digit_index  <= w_index_next;
      r_shadow       <= w_shadow_next;
      r_digit_select <= w_select_next;
      r_segment_out  <= w_segment_next;
      r_frame_start  <= w_frame_start_next;
    end
  end

  assign Digit_Select = r_digit_select;
  assign Segment_Out  = r_segment_out;
  assign Digit_Index  = r_digit_index;
  assign Frame_Start  = r_frame_start;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench for seven_seg_scan_driver: SCAN_DIV=8 with 2 and 0 blank cycles.
module tb_seven_seg_scan_driver;

  typedef struct {
    logic       fs;
    logic [7:0] dsel;
    logic [7:0] seg;
    logic [2:0] idx;
    int         gap;
    int         len;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, en, rst0_n, en0, sel0;
  logic [7:0] seg [8];
  logic [7:0] ds_a, so_a, ds_b, so_b;
  logic [2:0] di_a, di_b;
  logic       fs_a, fs_b;
  logic [7:0] m_dsel, m_seg;
  logic [2:0] m_idx;
  logic       m_fs;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(.SCAN_DIV(8), .BLANK_CYCLES(2)) dut (
    .Clock(clk), .Reset_n(rst_n), .Enable(en),
    .Seven_Seg0(seg[0]), .Seven_Seg1(seg[1]), .Seven_Seg2(seg[2]), .Seven_Seg3(seg[3]),
    .Seven_Seg4(seg[4]), .Seven_Seg5(seg[5]), .Seven_Seg6(seg[6]), .Seven_Seg7(seg[7]),
    .Digit_Select(ds_a), .Segment_Out(so_a), .Digit_Index(di_a), .Frame_Start(fs_a)
  );

  seven_seg_scan_driver #(.SCAN_DIV(8), .BLANK_CYCLES(0)) dut0 (
    .Clock(clk), .Reset_n(rst0_n), .Enable(en0),
    .Seven_Seg0(seg[0]), .Seven_Seg1(seg[1]), .Seven_Seg2(seg[2]), .Seven_Seg3(seg[3]),
    .Seven_Seg4(seg[4]), .Seven_Seg5(seg[5]), .Seven_Seg6(seg[6]), .Seven_Seg7(seg[7]),
    .Digit_Select(ds_b), .Segment_Out(so_b), .Digit_Index(di_b), .Frame_Start(fs_b)
  );

  assign m_dsel = sel0 ? ds_b : ds_a;
  assign m_seg  = sel0 ? so_b : so_a;
  assign m_idx  = sel0 ? di_b : di_a;
  assign m_fs   = sel0 ? fs_b : fs_a;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_fs(input int gap);
    exp_t e;
    e.fs = 1'b1; e.dsel = 8'hFF; e.seg = 8'hFF; e.idx = 3'd0; e.gap = gap; e.len = 0;
    q.push_back(e);
  endtask

  // One frame: Frame_Start then ndig lit digits; a truncated frame's last digit has no length check.
  task automatic push_frame(input int fs_gap, input int b, input logic [7:0] d3, input int ndig);
    exp_t       e;
    logic [7:0] one  = 8'h01;
    logic [7:0] base = 8'hC0;
    push_fs(fs_gap);
    for (int i = 0; i < ndig; i++) begin
      e.fs   = 1'b0;
      e.idx  = 3'(i);
      e.dsel = ~(one << i);
      e.seg  = (i == 3) ? d3 : base + 8'(i);
      e.gap  = (i == 0) ? b + 1 : 8;
      e.len  = ((i == ndig - 1) && (ndig < 8)) ? 0 : 8 - b;
      q.push_back(e);
    end
  endtask

  task automatic monitor_loop();
    int         cyc = 0, last_ev = 0, run_len = 0, exp_run = 0;
    logic [7:0] prev = 8'hFF;
    logic [7:0] one  = 8'h01;
    logic       safe;
    exp_t       e;
    forever begin
      @(negedge clk);
      cyc++;
      safe = (m_dsel == 8'hFF) ? (m_seg == 8'hFF) : (!m_fs && (m_dsel == ~(one << m_idx)));
      chk("onehot_dark", 64'(safe), 64'(1'b1));
      if ((prev != 8'hFF) && (m_dsel != prev)) begin
        if (exp_run > 0) chk("show_length", 64'(run_len), 64'(exp_run));
        run_len = 0;
      end
      if (m_dsel != 8'hFF) run_len++;
      if (m_fs || ((m_dsel != 8'hFF) && (m_dsel != prev))) begin
        if (q.size() == 0) begin
          chk("unexpected_event", 64'({m_fs, m_dsel}), 64'(0));
        end else begin
          e = q.pop_front();
          chk("ev_frame_start", 64'(m_fs), 64'(e.fs));
          chk("ev_digit_select", 64'(m_dsel), 64'(e.dsel));
          chk("ev_segment", 64'(m_seg), 64'(e.seg));
          chk("ev_index", 64'(m_idx), 64'(e.idx));
          if (e.gap >= 0) chk("ev_gap", 64'(cyc - last_ev), 64'(e.gap));
          exp_run = e.len;
        end
        last_ev = cyc;
      end
      prev = m_dsel;
    end
  endtask

  task automatic wait_lit(input int k);
    logic [7:0] one = 8'h01;
    int         n   = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((m_dsel !== ~(one << k)) && (n < 300));
    if (m_dsel !== ~(one << k)) begin
      checks++;
      errors++;
      $display("FAIL wait_digit%0d: timed out, select=%h", k, m_dsel);
    end
  endtask

  task automatic wait_fs();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((m_fs !== 1'b1) && (n < 300));
    if (m_fs !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_frame_start: timed out");
    end
  endtask

  task automatic chk_dark(input string name);
    chk({name, "_select"}, 64'(ds_a), 64'(8'hFF));
    chk({name, "_segment"}, 64'(so_a), 64'(8'hFF));
    chk({name, "_index"}, 64'(di_a), 64'(3'd0));
    chk({name, "_frame_start"}, 64'(fs_a), 64'(1'b0));
  endtask

  task automatic stimulus();
    logic [7:0] base = 8'hC0;
    rst_n = 1'b1; rst0_n = 1'b1; en = 1'b1; en0 = 1'b0; sel0 = 1'b0;
    for (int i = 0; i < 8; i++) seg[i] = base + 8'(i);
    #2 rst_n = 1'b0; rst0_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_dark("reset");
    chk("reset_shadow", 64'(dut.r_shadow), {8{8'hFF}});
    push_frame(-1, 2, 8'hC3, 8);
    @(negedge clk) rst_n = 1'b1; rst0_n = 1'b1;
    @(posedge clk) #1 chk("first_frame_start", 64'(fs_a), 64'(1'b1));

    // Input change mid-frame shows up only after the next snapshot.
    wait_lit(1);
    seg[3] = 8'hA4;
    push_frame(6, 2, 8'hA4, 8);
    wait_fs();
    wait_lit(1);
    seg[3] = 8'h99;
    push_frame(6, 2, 8'h99, 6);
    wait_fs();
    wait_lit(5);
    en = 1'b0;
    @(posedge clk) #1 chk_dark("enable_drop_show");
    repeat (3) @(negedge clk);
    push_frame(-1, 2, 8'h99, 3);
    en = 1'b1;
    @(posedge clk) #1 chk("restart_frame_start", 64'(fs_a), 64'(1'b1));
    chk("restart_index", 64'(di_a), 64'(3'd0));

    // Asynchronous reset pulse between edges during digit 2.
    wait_lit(2);
    push_frame(-1, 2, 8'h99, 8);
    push_fs(6);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_dark("async_reset");
    chk("async_reset_shadow", 64'(dut.r_shadow), {8{8'hFF}});
    #1 rst_n = 1'b1;
    @(posedge clk) #1 chk("post_reset_frame_start", 64'(fs_a), 64'(1'b1));
    chk("post_reset_shadow", 64'(dut.r_shadow), {8{8'hFF}});

    // Enable dropped during LOAD: no capture, straight to IDLE.
    wait_lit(7);
    wait_fs();
    en = 1'b0;
    seg[3] = 8'h88;
    @(posedge clk) #1 chk_dark("enable_drop_load");
    chk("shadow_retained", 64'(dut.r_shadow[3]), 64'(8'h99));
    repeat (3) @(negedge clk);

    // Zero blanking: back-to-back digits, 7 -> LOAD -> 0.
    sel0 = 1'b1;
    push_frame(-1, 0, 8'h88, 8);
    push_frame(8, 0, 8'h88, 8);
    push_fs(8);
    en0 = 1'b1;
    wait_lit(7);
    wait_fs();
    wait_lit(7);
    wait_fs();
    en0 = 1'b0;
    @(posedge clk) #1 chk("b0_idle_select", 64'(ds_b), 64'(8'hFF));
    chk("b0_idle_frame_start", 64'(fs_b), 64'(1'b0));
    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(q.size()), 64'(0));
  endtask

  initial begin
    fork
      monitor_loop();
      stimulus();
    join_any
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_driver.md
SEVEN_SEG_SCAN_DRIVER -- requirements
Module: seven_seg_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning clock cycles per digit slot; legal range 2 to 2^20.
REQ-002 SHALL have parameter BLANK_CYCLES, default 500, meaning blanked cycles at the start of each slot; legal range 0 to SCAN_DIV-1.
REQ-003 SHALL have port Clock  input  1  single clock for all state; rising edge.
REQ-004 SHALL have port Reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port Enable  input  1  scan enable; low holds the display dark.
REQ-006 SHALL have ports Seven_Seg0..Seven_Seg7  input  8 each  segment bytes from the data memory display registers, active-low segments, Seven_Seg0 is the rightmost digit.
REQ-007 SHALL have port Digit_Select  output  8  one-hot active-low anode drive, bit n is digit n.
REQ-008 SHALL have port Segment_Out  output  8  segment byte for the lit digit; 8'hFF when dark.
REQ-009 SHALL have port Digit_Index  output  3  digit slot currently being scanned.
REQ-010 SHALL have port Frame_Start  output  1  one-cycle pulse when a new snapshot is captured.

Function
REQ-011 SHALL implement states IDLE, LOAD, BLANK and SHOW, with all outputs registered and valid in the cycle the state is occupied.
REQ-012 IDLE SHALL drive Digit_Select=8'hFF and Segment_Out=8'hFF, and SHALL move to LOAD on the first cycle Enable is sampled high.
REQ-013 LOAD SHALL last exactly one cycle: capture all eight inputs into shadow registers, set Digit_Index=0, pulse Frame_Start=1, then go to BLANK, or to SHOW when BLANK_CYCLES=0.
REQ-014 BLANK SHALL last BLANK_CYCLES cycles with Digit_Select=8'hFF and Segment_Out=8'hFF, then go to SHOW.
REQ-015 SHOW SHALL last SCAN_DIV-BLANK_CYCLES cycles with Digit_Select bit Digit_Index low and Segment_Out equal to the shadow byte for Digit_Index.
REQ-016 At the end of SHOW with Digit_Index<7, the block SHALL increment Digit_Index and enter BLANK (SHOW if BLANK_CYCLES=0); with Digit_Index=7 it SHALL enter LOAD, giving a frame of 8*SCAN_DIV+1 cycles.
REQ-017 Input changes SHALL affect the display only at the next LOAD (frame-consistent); the shadow registers SHALL NOT update in BLANK or SHOW.
REQ-018 Enable sampled low in LOAD, BLANK or SHOW SHALL force IDLE on the next edge, clear the slot counter and Digit_Index, and retain the shadow registers.
REQ-019 The slot counter SHALL be ceil(log2(SCAN_DIV)) bits wide, count 0..SCAN_DIV-1, and wrap to 0 at each slot boundary without a dead cycle.
REQ-020 At most one Digit_Select bit SHALL be low in any cycle, and none SHALL be low outside SHOW.

Reset
REQ-021 Reset_n low SHALL asynchronously force: state IDLE, Digit_Select=8'hFF, Segment_Out=8'hFF, Digit_Index=0, Frame_Start=0, slot counter=0, all shadow bytes=8'hFF.
REQ-022 Reset asserted mid-slot SHALL darken all outputs immediately, and the block SHALL restart from IDLE to LOAD after release if Enable is high.

Structure
REQ-023 A shared package SHALL hold the state enumeration, NUM_DIGITS=8 and BLANK_SEG=8'hFF.
REQ-024 The slot prescaler SHALL be the single sub-module scan_tick_counter, with clear and enable inputs, a terminal-count pulse and a blank-window flag.

Verification (SCAN_DIV=8, BLANK_CYCLES=2 unless stated)
REQ-025 Reset release with Enable=1 and Seven_Seg0..7=8'hC0..8'hC7 -> Frame_Start pulse 1 cycle after the first sampled Enable; digit 0 shows 8'hC0 with Digit_Select=8'hFE for 6 cycles after 2 dark cycles; next Frame_Start exactly 65 cycles later.
REQ-026 Change Seven_Seg3 from 8'hA4 to 8'h99 during the SHOW of digit 1 -> digit 3 still shows 8'hA4 this frame and 8'h99 after the next Frame_Start.
REQ-027 Drop Enable during the SHOW of digit 5 -> next cycle IDLE with Digit_Select=8'hFF and Digit_Index=0; re-raise Enable -> LOAD then digit 0.
REQ-028 Pulse Reset_n low between clock edges during the SHOW of digit 2 -> outputs go dark before the next edge and shadow bytes read 8'hFF until the next LOAD.
REQ-029 Run with BLANK_CYCLES=0 -> no dark cycles between digits, SHOW slot lasts 8 cycles, Digit_Index wraps 7 to LOAD to 0.
REQ-030 Run with a one-hot checker over 3 full frames -> never more than one Digit_Select bit low, and none low in BLANK, LOAD or IDLE.
